// File: rtl/morse_keyer_pkg.sv
// Shared definitions for the morse keyer slice.
//   state_t      : keyer FSM states (3-bit encoding)
//   code_t       : one morse_rom entry {vld, len, pat}
//   NUM_LETTERS  : number of letter indices the ROM recognises (A..Z)
//   LEN_W/PAT_W  : widths of the element count and the element pattern
package morse_pkg;

  localparam int NUM_LETTERS = 26;
  localparam int LEN_W       = 3;
  localparam int PAT_W       = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_MARK  = 3'd2,
    S_SPACE = 3'd3,
    S_CGAP  = 3'd4
  } state_t;

  // pat[PAT_W-1] is the first element sent; 1 = dash, 0 = dot.
  typedef struct packed {
    logic             vld;
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
  } code_t;

endpackage

// File: rtl/morse_keyer_if.sv
// Letter handshake and key outputs of the morse keyer.
//   iCHAR/iVALID : letter index and its valid (driven by master)
//   oREADY       : keyer idle and able to take a letter
//   oKEY         : tone enable, oBUSY: letter in progress, oERR: bad index pulse
interface morse_keyer_if;
  logic [4:0] iCHAR;
  logic       iVALID;
  logic       oREADY;
  logic       oKEY;
  logic       oBUSY;
  logic       oERR;

  modport master (output iCHAR, iVALID, input oREADY, oKEY, oBUSY, oERR);
  modport slave  (input iCHAR, iVALID, output oREADY, oKEY, oBUSY, oERR);
endinterface

// File: rtl/morse_keyer_rom.sv
// morse_rom: combinational letter index -> ITU morse code.
//   idx  : letter index 0=A .. 25=Z
//   code : {vld, len, pat}; vld=0 for indices above Z. Unused pattern
//          bits (below the last element) are zero.
module morse_rom
  import morse_pkg::*;
(
  input  logic [4:0] idx,
  output code_t      code
);

  always_comb begin
    code = '{vld: 1'b1, len: 3'd0, pat: 4'b0000};
    unique case (idx)
      5'd0:  code = '{1'b1, 3'd2, 4'b0100}; // A .-
      5'd1:  code = '{1'b1, 3'd4, 4'b1000}; // B -...
      5'd2:  code = '{1'b1, 3'd4, 4'b1010}; // C -.-.
      5'd3:  code = '{1'b1, 3'd3, 4'b1000}; // D -..
      5'd4:  code = '{1'b1, 3'd1, 4'b0000}; // E .
      5'd5:  code = '{1'b1, 3'd4, 4'b0010}; // F ..-.
      5'd6:  code = '{1'b1, 3'd3, 4'b1100}; // G --.
      5'd7:  code = '{1'b1, 3'd4, 4'b0000}; // H ....
      5'd8:  code = '{1'b1, 3'd2, 4'b0000}; // I ..
      5'd9:  code = '{1'b1, 3'd4, 4'b0111}; // J .---
      5'd10: code = '{1'b1, 3'd3, 4'b1010}; // K -.-
      5'd11: code = '{1'b1, 3'd4, 4'b0100}; // L .-..
      5'd12: code = '{1'b1, 3'd2, 4'b1100}; // M --
      5'd13: code = '{1'b1, 3'd2, 4'b1000}; // N -.
      5'd14: code = '{1'b1, 3'd3, 4'b1110}; // O ---
      5'd15: code = '{1'b1, 3'd4, 4'b0110}; // P .--.
      5'd16: code = '{1'b1, 3'd4, 4'b1101}; // Q --.-
      5'd17: code = '{1'b1, 3'd3, 4'b0100}; // R .-.
      5'd18: code = '{1'b1, 3'd3, 4'b0000}; // S ...
      5'd19: code = '{1'b1, 3'd1, 4'b1000}; // T -
      5'd20: code = '{1'b1, 3'd3, 4'b0010}; // U ..-
      5'd21: code = '{1'b1, 3'd4, 4'b0001}; // V ...-
      5'd22: code = '{1'b1, 3'd3, 4'b0110}; // W .--
      5'd23: code = '{1'b1, 3'd4, 4'b1001}; // X -..-
      5'd24: code = '{1'b1, 3'd4, 4'b1011}; // Y -.--
      5'd25: code = '{1'b1, 3'd4, 4'b1100}; // Z --..
      default: code = '{1'b0, 3'd0, 4'b0000};
    endcase
  end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: takes one letter per handshake and keys it out in morse
// units, one unit per iTICK pulse.
//   iCLK, iRST_n : clock, asynchronous active-low reset
//   iTICK        : single-cycle unit strobe
//   bus          : letter handshake in, registered oREADY/oKEY/oBUSY/oERR out
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned DOT_UNITS      = 1,
  parameter int unsigned DASH_UNITS     = 3,
  parameter int unsigned ELEM_GAP_UNITS = 1,
  parameter int unsigned CHAR_GAP_UNITS = 3
) (
  input  logic          iCLK,
  input  logic          iRST_n,
  input  logic          iTICK,
  morse_keyer_if.slave  bus
);

  localparam logic [CNT_W-1:0] DOT_T  = CNT_W'(DOT_UNITS);
  localparam logic [CNT_W-1:0] DASH_T = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] EGAP_T = CNT_W'(ELEM_GAP_UNITS);
  localparam logic [CNT_W-1:0] CGAP_T = CNT_W'(CHAR_GAP_UNITS);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc, mark_t;
  logic [LEN_W-1:0] elem, elem_n;
  logic [PAT_W-1:0] sr, sr_n;
  logic             key, key_n;
  logic             ready, err, err_n, busy;
  code_t            code;

  morse_rom u_rom (
    .idx  (bus.iCHAR),
    .code (code)
  );

  // Targets are at most 7 and the count restarts on every state entry,
  // so cnt_inc never needs a fourth bit.
  assign cnt_inc = cnt + CNT_W'(1);
  assign mark_t  = sr[PAT_W-1] ? DASH_T : DOT_T;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    elem_n  = elem;
    sr_n    = sr;
    key_n   = key;
    err_n   = 1'b0;
    unique case (state)
      S_IDLE: begin
        key_n = 1'b0;
        if (bus.iVALID && ready) begin
          if (code.vld) begin
            sr_n    = code.pat;
            elem_n  = code.len;
            cnt_n   = '0;
            state_n = S_SYNC;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      // A tick in the transfer cycle is seen in IDLE and dropped; the first
      // tick seen here aligns the mark to the unit grid.
      S_SYNC: begin
        if (iTICK) begin
          state_n = S_MARK;
          cnt_n   = '0;
          key_n   = 1'b1;
        end
      end
      S_MARK: begin
        if (iTICK) begin
          if (cnt_inc == mark_t) begin
            key_n  = 1'b0;
            cnt_n  = '0;
            elem_n = elem - LEN_W'(1);
            if (elem == LEN_W'(1)) begin
              state_n = S_CGAP;
            end else begin
              state_n = S_SPACE;
              sr_n    = {sr[PAT_W-2:0], 1'b0};
            end
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_SPACE: begin
        if (iTICK) begin
          if (cnt_inc == EGAP_T) begin
            state_n = S_MARK;
            cnt_n   = '0;
            key_n   = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      S_CGAP: begin
        if (iTICK) begin
          if (cnt_inc == CGAP_T) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        key_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      elem  <= '0;
      sr    <= '0;
      key   <= 1'b0;
      err   <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      elem  <= elem_n;
      sr    <= sr_n;
      key   <= key_n;
      err   <= err_n;
      ready <= (state_n == S_IDLE);
      busy  <= (state_n != S_IDLE);
    end
  end

  assign bus.oREADY = ready;
  assign bus.oKEY   = key;
  assign bus.oBUSY  = busy;
  assign bus.oERR   = err;

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer. A tick-timeline model built from
// dot/dash strings predicts every output each cycle; literal run-length
// checks pin the model to hand-computed key timings.
module tb_morse_keyer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick = 1'b0;
  always #5 clk = ~clk;

  morse_keyer_if kif ();
  morse_keyer_if kif2 ();

  morse_keyer u_dut (.iCLK(clk), .iRST_n(rst_n), .iTICK(tick), .bus(kif.slave));
  morse_keyer #(.DASH_UNITS(5)) u_dut5 (.iCLK(clk), .iRST_n(rst_n), .iTICK(tick), .bus(kif2.slave));

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main DUT, default units) --------
  string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};
  bit lvl[$];
  bit m_idle = 1'b1;
  bit m_sync = 1'b0;
  bit m_err  = 1'b0;
  int m_n    = 0;

  // Key level for each tick interval after the aligning tick.
  task automatic build(input int idx);
    string s;
    s = codes[idx];
    lvl.delete();
    for (int j = 0; j < s.len(); j++) begin
      int mk;
      int gp;
      mk = (s[j] == 8'h2D) ? 3 : 1;
      gp = (j == s.len() - 1) ? 3 : 1;
      for (int k = 0; k < mk; k++) lvl.push_back(1'b1);
      for (int k = 0; k < gp; k++) lvl.push_back(1'b0);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_idle = 1'b1; m_sync = 1'b0; m_err = 1'b0; m_n = 0;
    end else begin
      m_err = 1'b0;
      if (m_idle) begin
        if (kif.iVALID) begin
          if (kif.iCHAR < 5'd26) begin
            build(int'(kif.iCHAR));
            m_idle = 1'b0; m_sync = 1'b0; m_n = 0;
          end else begin
            m_err = 1'b1;
          end
        end
      end else if (!m_sync) begin
        if (tick) begin m_sync = 1'b1; m_n = 0; end
      end else if (tick) begin
        m_n++;
        if (m_n == lvl.size()) m_idle = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      bit ek;
      ek = !m_idle && m_sync && (m_n < lvl.size()) && lvl[m_n];
      cmp("model_key",   int'(kif.oKEY),   int'(ek));
      cmp("model_ready", int'(kif.oREADY), int'(m_idle));
      cmp("model_busy",  int'(kif.oBUSY),  int'(!m_idle));
      cmp("model_err",   int'(kif.oERR),   int'(m_err));
    end
  end

  // ---------------- key run-length recorders ---------------------------
  int run1 = 0, run2 = 0;
  int runs1[$];
  int runs2[$];
  always @(posedge clk) begin
    #1;
    if (kif.oKEY) run1++;
    else begin if (run1 > 0) runs1.push_back(run1); run1 = 0; end
    if (kif2.oKEY) run2++;
    else begin if (run2 > 0) runs2.push_back(run2); run2 = 0; end
  end

  function automatic int rget1(input int i);
    return (i < runs1.size()) ? runs1[i] : -1;
  endfunction

  // ---------------- stimulus --------------------------------------------
  int tmode = 0;   // 0 none, 1 periodic, 2 random
  int tp    = 10;
  int tcnt  = 0;

  task automatic step();
    @(negedge clk);
    tcnt++;
    case (tmode)
      1:       tick = ((tcnt % tp) == 0);
      2:       tick = ($urandom_range(0, 3) == 0);
      default: tick = 1'b0;
    endcase
  endtask

  task automatic send1(input logic [4:0] c, input bit keep);
    int n;
    n = 0;
    step();
    kif.iVALID = 1'b1;
    kif.iCHAR  = c;
    while (!kif.oREADY && n < 3000) begin step(); n++; end
    cmp("send_timeout", int'(n < 3000), 1);
    step();
    if (!keep) kif.iVALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((kif.oBUSY || !kif.oREADY) && n < 5000) begin step(); n++; end
    cmp("idle_timeout", int'(n < 5000), 1);
  endtask

  initial begin
    int n;
    kif.iVALID = 1'b1; kif.iCHAR = 5'd0;
    kif2.iVALID = 1'b0; kif2.iCHAR = 5'd0;
    #1 rst_n = 1'b0;
    repeat (4) step();
    cmp("rst_ready", int'(kif.oREADY), 1);
    cmp("rst_key",   int'(kif.oKEY),   0);
    cmp("rst_busy",  int'(kif.oBUSY),  0);
    cmp("rst_err",   int'(kif.oERR),   0);
    kif.iVALID = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    cmp("post_rst_ready", int'(kif.oREADY), 1);

    // E with a tick every 10 clocks
    tmode = 1; tp = 10;
    runs1.delete();
    send1(5'd4, 1'b0);
    wait_idle();
    cmp("E_runs", runs1.size(), 1);
    cmp("E_mark", rget1(0), 10);

    // A then Q held valid straight after
    runs1.delete();
    send1(5'd0, 1'b1);
    kif.iCHAR = 5'd16;
    cmp("A_busy_blocks_Q", int'(kif.oREADY), 0);
    send1(5'd16, 1'b0);
    wait_idle();
    cmp("AQ_runs", runs1.size(), 6);
    cmp("A_m0", rget1(0), 10);
    cmp("A_m1", rget1(1), 30);
    cmp("Q_m0", rget1(2), 30);
    cmp("Q_m1", rget1(3), 30);
    cmp("Q_m2", rget1(4), 10);
    cmp("Q_m3", rget1(5), 30);

    // invalid index
    runs1.delete();
    send1(5'd27, 1'b0);
    cmp("inv_err",   int'(kif.oERR),   1);
    cmp("inv_ready", int'(kif.oREADY), 1);
    step();
    cmp("inv_err_pulse", int'(kif.oERR),   0);
    cmp("inv_ready2",    int'(kif.oREADY), 1);
    repeat (30) step();
    cmp("inv_no_key", runs1.size(), 0);

    // reset two ticks into the dash of T
    send1(5'd19, 1'b0);
    n = 0;
    while (!kif.oKEY && n < 200) begin step(); n++; end
    cmp("T_key_rise", int'(kif.oKEY), 1);
    repeat (20) step();
    cmp("T_mid_dash", int'(kif.oKEY), 1);
    #2 rst_n = 1'b0;
    #1;
    cmp("T_rst_key",   int'(kif.oKEY),   0);
    cmp("T_rst_busy",  int'(kif.oBUSY),  0);
    cmp("T_rst_ready", int'(kif.oREADY), 1);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    runs1.delete();
    send1(5'd19, 1'b0);
    wait_idle();
    cmp("T_resend_runs", runs1.size(), 1);
    cmp("T_resend_mark", rget1(0), 30);

    // tick coincident with acceptance, DASH_UNITS=5 instance
    runs2.delete();
    n = 0;
    do begin step(); n++; end while (!tick && n < 50);
    kif2.iVALID = 1'b1; kif2.iCHAR = 5'd19;
    step();
    kif2.iVALID = 1'b0;
    cmp("T5_accepted", int'(kif2.oBUSY), 1);
    for (int i = 1; i < 10; i++) begin
      step();
      cmp("T5_sync_wait", int'(kif2.oKEY), 0);
    end
    step();
    step();
    cmp("T5_key_rise", int'(kif2.oKEY), 1);
    n = 0;
    while ((kif2.oBUSY || !kif2.oREADY) && n < 2000) begin step(); n++; end
    cmp("T5_timeout", int'(n < 2000), 1);
    cmp("T5_runs", runs2.size(), 1);
    cmp("T5_mark", (runs2.size() > 0) ? runs2[0] : -1, 50);

    // randomized letters and ticks, checked by the model
    tmode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 5)) step();
      send1(5'($urandom_range(0, 31)), 1'b0);
    end
    wait_idle();
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
Upstream sequencer for the morse tone stage. Accepts one letter at a time (A–Z index) over a valid/ready handshake. Emits a key-on level timed in morse units, where one unit is one pulse of the unit tick supplied by the tick divider (iTICK, nominally 4 Hz). oKEY gates the tone generator downstream.

Parameters:
DOT_UNITS, 1, mark length of a dot in ticks (1..7)
DASH_UNITS, 3, mark length of a dash in ticks (1..7)
ELEM_GAP_UNITS, 1, space between elements of one letter (1..7)
CHAR_GAP_UNITS, 3, space after the last element of a letter (1..7)

Ports:
iCLK  in  1  system clock; all logic rising-edge
iRST_n  in  1  reset, asynchronous assert, active-low
iTICK  in  1  unit strobe; single-cycle pulse, synchronous to iCLK
iCHAR  in  5  letter index, 0=A .. 25=Z
iVALID  in  1  iCHAR valid
oREADY  out  1  block can accept a letter
oKEY  out  1  tone enable (1 = mark)
oBUSY  out  1  letter in progress (state != IDLE)
oERR  out  1  one-cycle pulse when an index >25 is accepted

Behaviour:
- Reset (iRST_n=0, asynchronous): state=IDLE, oKEY=0, oBUSY=0, oERR=0, oREADY=1, all counters 0. Reset mid-letter aborts the letter immediately. oKEY drops asynchronously with reset.
- All outputs are registered.
- Handshake:
  - Transfer occurs on a rising edge with iVALID=1 and oREADY=1.
  - oREADY=1 only in IDLE.
  - iCHAR is sampled only at the transfer.
- Code table (morse_rom):
  - iCHAR maps to len[2:0] (1..4) and pat[3:0]. pat[3] is the first element; 1=dash, 0=dot.
  - Standard ITU letters, e.g. A: len=2, pat=01xx. E: len=1, pat=0xxx. Q: len=4, pat=1101.
- States: IDLE, SYNC, MARK, SPACE, CGAP.
  - IDLE, valid index accepted: latch len/pat into a shift register and element counter → SYNC. oBUSY=1 next cycle.
  - IDLE, index >25 accepted: oERR=1 for one cycle, stay IDLE, oKEY stays 0.
  - SYNC: wait for the first iTICK → MARK. oKEY=1 from the cycle after that tick.
  - MARK: count iTICK. At DOT_UNITS or DASH_UNITS ticks (per current element), oKEY=0 and decrement the element counter:
    - elements remain → SPACE (shift pattern left)
    - none remain → CGAP
  - SPACE: after ELEM_GAP_UNITS ticks → MARK, oKEY=1.
  - CGAP: after CHAR_GAP_UNITS ticks → IDLE. oREADY=1 the cycle after.
- Timing: a tick landing in the same cycle as the transfer is ignored; alignment always goes through SYNC.
- Simultaneous events: iVALID is ignored while busy. An iTICK coinciding with a state transition counts only toward the state being left.
- Unit counter: 3 bits, cleared on every state entry, never wraps. The compare is an equality at the target count.
- Total ticks per letter from the first MARK tick = sum(marks) + (len−1)·ELEM_GAP + CHAR_GAP. Example: A = 1+1+3+3 = 8 ticks.

Decomposition:
- Shared package morse_pkg holds:
  - state encoding localparams (IDLE..CGAP, 3 bits)
  - NUM_LETTERS=26
  - code-width constants: LEN_W=3, PAT_W=4
- Sub-module morse_rom: combinational iCHAR → {valid, len, pat} case table, instantiated once.
- Everything else lives in morse_keyer.

Test Plan:
- Reset: hold iRST_n=0 with iVALID=1 → oREADY=1, oKEY=0, oBUSY=0, no transfer. Release → normal operation.
- Send 'E' (iCHAR=4), tick every 10 clocks → oKEY high for exactly 1 tick period, then low for 3 ticks, then oREADY=1. 4 ticks total after SYNC.
- Send 'A' (0), then immediately 'Q' (16) held valid:
  - A keyed as 1 on / 1 off / 3 on / 3 off.
  - Q accepted only after A's CGAP, then keyed as dash-dash-dot-dash = 3,1,3,1,1,1,3 then 3 gap.
- Invalid index 27 → oERR single-cycle pulse, oKEY never asserted, oREADY stays 1 next cycle.
- Reset mid-dash of 'T' (19), 2 ticks into the mark → oKEY=0 immediately. After release, 'T' must be resent and yields a full 3-tick mark.
- Tick coincident with acceptance → ignored. The mark begins on the following tick, so the mark length is exact in tick counts (checked with DASH_UNITS=5 override on 'T': 5 ticks).
